ext_bus_sample_fetcher: RTL

//  Initiator for the SoC external-bus bridge interface. Fetches a run of 16-bit

---
 rtl/ext_bus_sample_fetcher_if.sv | 31 +++
 rtl/ext_bus_sample_fetcher.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ext_bus_sample_fetcher_if.sv
// Bridge read bus plus audio sample stream seen by ext_bus_sample_fetcher.
// master = the fetcher's view, slave = the bridge/consumer view.
interface ext_bus_sample_fetcher_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] bus_address;
    logic [1:0]        bus_byte_enable;
    logic              bus_read;
    logic              bus_write;
    logic [DATA_W-1:0] bus_write_data;
    logic              bus_acknowledge;
    logic [DATA_W-1:0] bus_read_data;
    logic [DATA_W-1:0] smp_data;
    logic              smp_valid;
    logic              smp_ready;

    // bus_read holds a stable bus_address until the cycle bus_acknowledge is high, and that
    // cycle carries bus_read_data; a sample moves on every cycle with smp_valid && smp_ready.
    modport master (
        output bus_address, bus_byte_enable, bus_read, bus_write, bus_write_data,
        output smp_data, smp_valid,
        input  bus_acknowledge, bus_read_data, smp_ready
    );

    modport slave (
        input  bus_address, bus_byte_enable, bus_read, bus_write, bus_write_data,
        input  smp_data, smp_valid,
        output bus_acknowledge, bus_read_data, smp_ready
    );
endinterface

// File: rtl/ext_bus_sample_fetcher.sv
// Fetches a run of 16-bit words over the external-bus bridge into a sample FIFO.
// Optional macro BYTE_SWAP_EN swaps the two bytes of every word pushed (big-endian stream).
module ext_bus_sample_fetcher #(
    parameter int ADDR_W         = 26,
    parameter int DATA_W         = 16,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        start_addr,
    input  logic [15:0]              word_count,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [2:0]               dbg_state_o,
    ext_bus_sample_fetcher_if.master bus_if
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_GAP, S_STALL, S_DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       rem_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              busy_q, done_q, error_q, read_q;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              fifo_full, push, pop;
    logic [DATA_W-1:0] push_data;

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    // abort discards an acknowledge landing in the same cycle and blocks the pop
    assign push = (state_q == S_READ) && bus_if.bus_acknowledge && !abort;
    assign pop  = bus_if.smp_ready && (count_q != '0) && !abort;

`ifdef BYTE_SWAP_EN
    assign push_data = {bus_if.bus_read_data[7:0], bus_if.bus_read_data[DATA_W-1:8]};
`else
    assign push_data = bus_if.bus_read_data;
`endif

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            read_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                read_q  <= 1'b0;
                tmo_q   <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: if (start) begin
                        addr_q  <= start_addr & ~ADDR_W'(1);
                        rem_q   <= word_count;
                        error_q <= 1'b0;
                        tmo_q   <= '0;
                        busy_q  <= 1'b1;
                        if (word_count == 16'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (fifo_full) begin
                            state_q <= S_STALL;
                        end else begin
                            state_q <= S_READ;
                            read_q  <= 1'b1;
                        end
                    end
                    S_READ: if (bus_if.bus_acknowledge) begin
                        addr_q <= addr_q + ADDR_W'(2);
                        rem_q  <= rem_q - 16'd1;
                        read_q <= 1'b0;
                        tmo_q  <= '0;
                        if (rem_q == 16'd1) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        error_q <= 1'b1;
                        read_q  <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                    S_GAP, S_STALL: if (!fifo_full) begin
                        state_q <= S_READ;
                        read_q  <= 1'b1;
                    end else begin
                        state_q <= S_STALL;
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        read_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign dbg_state_o = state_q;

    assign bus_if.bus_address     = addr_q;
    assign bus_if.bus_read        = read_q;
    assign bus_if.bus_byte_enable = read_q ? 2'b11 : 2'b00;
    assign bus_if.bus_write       = 1'b0;
    assign bus_if.bus_write_data  = '0;
    assign bus_if.smp_valid       = (count_q != '0);
    assign bus_if.smp_data        = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
endmodule
